fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: hazard/redirect requests from the pipeline and the
// stall/flush/redirect controls returned to it.
interface fetch_ctrl_if;
   logic        BranchTaken_E;
   logic [63:0] BranchTarget_E;
   logic        Jump_D;
   logic [63:0] JumpTarget_D;
   logic        LoadUse_D;
   logic        PCWrite_F;
   logic [63:0] PCTarget;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        FlushE;
   logic        Halted;
   logic [63:0] BadTarget;
   logic [31:0] RedirectCount;

   // Pipeline side: raises requests, consumes controls.
   modport master (
      output BranchTaken_E, BranchTarget_E, Jump_D, JumpTarget_D, LoadUse_D,
      input  PCWrite_F, PCTarget, StallF, StallD, FlushD, FlushE,
      input  Halted, BadTarget, RedirectCount
   );

   // Controller side.
   modport slave (
      input  BranchTaken_E, BranchTarget_E, Jump_D, JumpTarget_D, LoadUse_D,
      output PCWrite_F, PCTarget, StallF, StallD, FlushD, FlushE,
      output Halted, BadTarget, RedirectCount
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: boot hold, branch/jump redirect with load-use stalls,
// and a sticky halt on a misaligned redirect target.
module fetch_ctrl #(
   parameter int unsigned BOOT_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst,
   fetch_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_boot_cnt;
   logic [63:0] r_bad_target;
   logic [31:0] r_redirect_cnt;

   logic        w_redir;
   logic        w_redir_branch;
   logic [63:0] w_target;
   logic        w_misalign;
   logic        w_pcwrite;
   logic [63:0] w_pctarget;
   logic        w_stallf;
   logic        w_stalld;
   logic        w_flushd;
   logic        w_flushe;
   logic        w_halted;

   // A branch outranks everything; a load-use stall defers a jump by a cycle.
   always_comb begin
      w_redir        = 1'b0;
      w_redir_branch = 1'b0;
      w_target       = '0;
      if (!rst && r_state == ST_RUN) begin
         if (bus.BranchTaken_E) begin
            w_redir        = 1'b1;
            w_redir_branch = 1'b1;
            w_target       = bus.BranchTarget_E;
         end else if (!bus.LoadUse_D && bus.Jump_D) begin
            w_redir  = 1'b1;
            w_target = bus.JumpTarget_D;
         end
      end
   end

   assign w_misalign = w_redir && (w_target[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_BOOT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_BOOT: if (r_boot_cnt == 4'd1) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_misalign)         w_state_nxt = ST_HALT;
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_BOOT;
      endcase
   end

   always_comb begin
      w_pcwrite  = 1'b0;
      w_pctarget = '0;
      w_stallf   = 1'b0;
      w_stalld   = 1'b0;
      w_flushd   = 1'b0;
      w_flushe   = 1'b0;
      w_halted   = 1'b0;
      if (rst) begin
         w_stallf = 1'b1;
         w_flushd = 1'b1;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_misalign) begin
                  w_stallf = 1'b1;
                  w_flushd = 1'b1;
                  w_flushe = 1'b1;
               end else if (w_redir) begin
                  w_pcwrite  = 1'b1;
                  w_pctarget = w_target;
                  w_flushd   = 1'b1;
                  w_flushe   = w_redir_branch;
               end else if (bus.LoadUse_D) begin
                  w_stallf = 1'b1;
                  w_stalld = 1'b1;
                  w_flushe = 1'b1;
               end
            end
            ST_HALT: begin
               w_stallf = 1'b1;
               w_flushd = 1'b1;
               w_flushe = 1'b1;
               w_halted = 1'b1;
            end
            default: begin
               w_stallf = 1'b1;
               w_flushd = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_boot_cnt <= 4'(BOOT_CYCLES);
      end else if (r_state == ST_BOOT && r_boot_cnt != 4'd1) begin
         r_boot_cnt <= r_boot_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bad_target   <= '0;
         r_redirect_cnt <= '0;
      end else begin
         if (w_misalign) r_bad_target <= w_target;
         // Saturate rather than wrap.
         if (w_pcwrite && r_redirect_cnt != 32'hFFFF_FFFF)
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
      end
   end

   assign bus.PCWrite_F     = w_pcwrite;
   assign bus.PCTarget      = w_pctarget;
   assign bus.StallF        = w_stallf;
   assign bus.StallD        = w_stalld;
   assign bus.FlushD        = w_flushd;
   assign bus.FlushE        = w_flushe;
   assign bus.Halted        = w_halted;
   assign bus.BadTarget     = r_bad_target;
   assign bus.RedirectCount = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a
// behavioural model of the controller and a small fetch-PC register.
module tb_fetch_ctrl;

   localparam int BOOT_N  = 2;
   localparam int PH_BOOT = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_HALT = 2;

   logic clk;
   logic rst;
   fetch_ctrl_if bus();

   fetch_ctrl #(.BOOT_CYCLES(BOOT_N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fetch PC driven by the controller outputs.
   logic [63:0] tb_pc = '0;
   always @(posedge clk) begin
      if (rst)                tb_pc <= '0;
      else if (bus.PCWrite_F) tb_pc <= bus.PCTarget;
      else if (!bus.StallF)   tb_pc <= tb_pc + 64'd4;
   end

   int n_chk = 0;
   int n_err = 0;

   int          m_phase = PH_BOOT;
   int          m_left  = BOOT_N;
   logic [63:0] m_bad   = '0;
   logic [31:0] m_cnt   = '0;
   logic [63:0] m_pc    = '0;

   logic        e_pcw, e_sf, e_sd, e_fd, e_fe, e_halt;
   logic [63:0] e_tgt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_outputs(input logic r, input logic bt, input logic [63:0] bt_t,
                                input logic lu, input logic jd, input logic [63:0] jd_t);
      logic        want;
      logic        is_br;
      logic [63:0] t;
      e_pcw = 0; e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0; e_halt = 0; e_tgt = '0;
      want = 0; is_br = 0; t = '0;
      if (r || m_phase == PH_BOOT) begin
         e_sf = 1; e_fd = 1;
      end else if (m_phase == PH_HALT) begin
         e_sf = 1; e_fd = 1; e_fe = 1; e_halt = 1;
      end else begin
         if (bt) begin
            want = 1; is_br = 1; t = bt_t;
         end else if (lu) begin
            e_sf = 1; e_sd = 1; e_fe = 1;
         end else if (jd) begin
            want = 1; t = jd_t;
         end
         if (want) begin
            if (t % 4 != 0) begin
               e_sf = 1; e_fd = 1; e_fe = 1;
            end else begin
               e_pcw = 1; e_tgt = t; e_fd = 1; e_fe = is_br;
            end
         end
      end
   endtask

   task automatic model_advance(input logic r, input logic bt, input logic [63:0] bt_t,
                                input logic lu, input logic jd, input logic [63:0] jd_t);
      logic [63:0] t;
      if (r) begin
         m_phase = PH_BOOT; m_left = BOOT_N; m_bad = '0; m_cnt = '0; m_pc = '0;
         return;
      end
      if (e_pcw)      m_pc = e_tgt;
      else if (!e_sf) m_pc = m_pc + 64'd4;
      if (e_pcw && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      case (m_phase)
         PH_BOOT: if (m_left == 1) m_phase = PH_RUN; else m_left = m_left - 1;
         PH_RUN: begin
            t = bt ? bt_t : (!lu && jd) ? jd_t : 64'd0;
            if ((bt || (!lu && jd)) && t % 4 != 0) begin
               m_bad = t; m_phase = PH_HALT;
            end
         end
         default: ;
      endcase
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic r, input logic bt, input logic [63:0] bt_t,
                       input logic lu, input logic jd, input logic [63:0] jd_t);
      rst = r;
      bus.BranchTaken_E = bt; bus.BranchTarget_E = bt_t;
      bus.LoadUse_D = lu; bus.Jump_D = jd; bus.JumpTarget_D = jd_t;
      model_outputs(r, bt, bt_t, lu, jd, jd_t);
      #2;
      chk("ctl", {58'd0, bus.PCWrite_F, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.Halted},
                 {58'd0, e_pcw, e_sf, e_sd, e_fd, e_fe, e_halt});
      chk("pctarget", bus.PCTarget, e_tgt);
      chk("badtarget", bus.BadTarget, m_bad);
      chk("redircnt", {32'd0, bus.RedirectCount}, {32'd0, m_cnt});
      chk("fetch_pc", tb_pc, m_pc);
      @(posedge clk);
      model_advance(r, bt, bt_t, lu, jd, jd_t);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 64'd0, 0, 0, 64'd0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 64'd0, 0, 0, 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.BranchTaken_E = 0; bus.BranchTarget_E = '0;
      bus.LoadUse_D = 0; bus.Jump_D = 0; bus.JumpTarget_D = '0;
      @(posedge clk);
      @(negedge clk);

      // Boot hold then free-running fetch
      do_reset(2);
      idle(5);

      // Branch redirect
      step(0, 1, 64'h28, 0, 0, 64'd0);
      idle(2);

      // Simultaneous requests, then load-use deferring a jump
      step(0, 1, 64'h40, 1, 1, 64'h80);
      step(0, 0, 64'd0,  1, 1, 64'h80);
      step(0, 0, 64'd0,  0, 1, 64'h80);
      idle(1);

      // Counter saturation
      force dut.r_redirect_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_redirect_cnt;
      m_cnt = 32'hFFFF_FFFE;
      step(0, 1, 64'h100, 0, 0, 64'd0);
      step(0, 1, 64'h200, 0, 0, 64'd0);
      step(0, 0, 64'd0,   0, 1, 64'h300);
      idle(1);

      // Misaligned jump halts; halt ignores requests until reset
      step(0, 0, 64'd0, 0, 1, 64'h22);
      step(0, 1, 64'h40, 0, 0, 64'd0);
      step(0, 0, 64'd0, 1, 1, 64'h80);
      idle(1);
      do_reset(1);
      idle(3);

      // Reset in the middle of a load-use stall
      step(0, 0, 64'd0, 1, 0, 64'd0);
      step(0, 0, 64'd0, 1, 0, 64'd0);
      step(1, 0, 64'd0, 1, 0, 64'd0);
      step(0, 0, 64'd0, 1, 1, 64'h44);
      step(0, 0, 64'd0, 1, 1, 64'h44);
      step(0, 0, 64'd0, 1, 1, 64'h44);
      idle(1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic        r, bt, lu, jd;
         logic [63:0] bt_t, jd_t;
         r    = ($urandom_range(0, 39) == 0);
         bt   = ($urandom_range(0, 3) == 0);
         lu   = ($urandom_range(0, 3) == 0);
         jd   = ($urandom_range(0, 2) == 0);
         bt_t = {$urandom, $urandom};
         jd_t = {$urandom, $urandom};
         if ($urandom_range(0, 15) != 0) bt_t[1:0] = 2'b00;
         if ($urandom_range(0, 15) != 0) jd_t[1:0] = 2'b00;
         step(r, bt, bt_t, lu, jd, jd_t);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
